// File: rtl/deserialize_pkg.sv
`default_nettype none
// ============================================================================
// deserialize_pkg : shared {index, data} tag layout used by serialize and
//                   deserialize so both ends agree on the word format.
// Revision       : 1.0
// ============================================================================
package deserialize_pkg;

   // Width of the channel index field; a single channel still carries one bit.
   function automatic int sel_width(input int argn);
      return (argn > 1) ? $clog2(argn) : 1;
   endfunction

   // The index field sits directly above the data field.
   function automatic int tag_idx_lsb(input int argw);
      return argw;
   endfunction

   function automatic int tag_width(input int argn, input int argw);
      return sel_width(argn) + argw;
   endfunction

endpackage
`default_nettype wire

// File: rtl/chan_fifo.sv
`default_nettype none
// ============================================================================
// chan_fifo : per-channel register FIFO with wrap-bit read/write pointers.
// Revision  : 1.0
// ============================================================================
module chan_fifo #(
   parameter int ARGW  = 16,
   parameter int DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic [ARGW-1:0] din,
   output logic            full,
   input  logic            pop,
   output logic [ARGW-1:0] dout,
   output logic            empty
);
   localparam int c_aw = $clog2(DEPTH);

   logic [c_aw:0]   r_wptr;
   logic [c_aw:0]   r_rptr;
   logic [ARGW-1:0] r_mem [DEPTH];
   logic            w_push;
   logic            w_pop;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign full   = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                   (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
   assign empty  = (r_wptr == r_rptr);
   assign w_push = push & ~full;
   assign w_pop  = pop & ~empty;
   assign dout   = r_mem[r_rptr[c_aw-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + (c_aw+1)'(1);
         if (w_pop)  r_rptr <= r_rptr + (c_aw+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[c_aw-1:0]] <= din;
   end

endmodule
`default_nettype wire

// File: rtl/deserialize.sv
`default_nettype none
// ============================================================================
// deserialize : routes a tagged {index, data} stream into ARGN independently
//               drained per-channel FIFOs.
// Revision    : 1.0
// ============================================================================
module deserialize
   import deserialize_pkg::*;
#(
   parameter int ARGW  = 16,
   parameter int ARGN  = 2,
   parameter int DEPTH = 2
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              arg_stb,
   input  logic [tag_width(ARGN, ARGW)-1:0]  arg_dat,
   output logic                              arg_rdy,
   output logic [ARGN-1:0]                   res_stb,
   output logic [ARGN*ARGW-1:0]              res_dat,
   input  logic [ARGN-1:0]                   res_rdy,
   output logic                              err
);
   localparam int c_selw    = sel_width(ARGN);
   localparam int c_idx_lsb = tag_idx_lsb(ARGW);

   logic [c_selw-1:0] w_sel;
   logic [ARGW-1:0]   w_data;
   logic              w_in_range;
   logic              w_sel_full;
   logic [ARGN-1:0]   w_full;
   logic [ARGN-1:0]   w_empty;
   logic [ARGN-1:0]   w_push;
   logic              r_err;

   assign w_sel  = arg_dat[c_idx_lsb +: c_selw];
   assign w_data = arg_dat[ARGW-1:0];

   generate
      if ((1 << c_selw) == ARGN) begin : g_pow2
         assign w_in_range = 1'b1;
      end else begin : g_npow2
         localparam logic [c_selw-1:0] c_argn = c_selw'(ARGN);
         assign w_in_range = (w_sel < c_argn);
      end
   endgenerate

   always_comb begin
      w_sel_full = 1'b0;
      for (int i = 0; i < ARGN; i++) begin
         if (w_sel == c_selw'(i)) w_sel_full = w_full[i];
      end
   end

   // Out-of-range words are always accepted so they can be dropped.
   assign arg_rdy = ~w_in_range | ~w_sel_full;

   generate
      for (genvar n = 0; n < ARGN; n++) begin : g_chan
         assign w_push[n] = arg_stb & arg_rdy & w_in_range & (w_sel == c_selw'(n));

         chan_fifo #(
            .ARGW  (ARGW),
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (w_push[n]),
            .din   (w_data),
            .full  (w_full[n]),
            .pop   (res_rdy[n]),
            .dout  (res_dat[n*ARGW +: ARGW]),
            .empty (w_empty[n])
         );

         assign res_stb[n] = ~w_empty[n];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (arg_stb & ~w_in_range) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_deserialize.sv
`default_nettype none
// ============================================================================
// tb_deserialize : directed stimulus with queue scoreboard for deserialize.
// Revision       : 1.0
// ============================================================================
module tb_deserialize;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        arg_stb;
   logic [16:0] arg_dat;
   logic        arg_rdy;
   logic [1:0]  res_stb;
   logic [31:0] res_dat;
   logic [1:0]  res_rdy;
   logic        err;

   logic        a3_stb;
   logic [17:0] a3_dat;
   logic        a3_rdy;
   logic [2:0]  r3_stb;
   logic [47:0] r3_dat;
   logic [2:0]  r3_rdy;
   logic        err3;

   int n_checks = 0;
   int n_fail   = 0;
   int pops [2];
   logic [15:0] q0 [$];
   logic [15:0] q1 [$];

   deserialize #(.ARGW(16), .ARGN(2), .DEPTH(2)) u_dut (
      .clk(clk), .rst(rst), .arg_stb(arg_stb), .arg_dat(arg_dat), .arg_rdy(arg_rdy),
      .res_stb(res_stb), .res_dat(res_dat), .res_rdy(res_rdy), .err(err)
   );

   deserialize #(.ARGW(16), .ARGN(3), .DEPTH(2)) u_dut3 (
      .clk(clk), .rst(rst), .arg_stb(a3_stb), .arg_dat(a3_dat), .arg_rdy(a3_rdy),
      .res_stb(r3_stb), .res_dat(r3_dat), .res_rdy(r3_rdy), .err(err3)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every pop on the two-channel DUT is compared against the scoreboard.
   always @(negedge clk) begin
      logic [15:0] e;
      if (!rst) begin
         if (res_stb[0] && res_rdy[0]) begin
            pops[0]++;
            if (q0.size() == 0) check("ch0_spurious", 64'(res_dat[15:0]), 64'hDEAD_0000);
            else begin
               e = q0.pop_front();
               check("ch0_data", 64'(res_dat[15:0]), 64'(e));
            end
         end
         if (res_stb[1] && res_rdy[1]) begin
            pops[1]++;
            if (q1.size() == 0) check("ch1_spurious", 64'(res_dat[31:16]), 64'hDEAD_0000);
            else begin
               e = q1.pop_front();
               check("ch1_data", 64'(res_dat[31:16]), 64'(e));
            end
         end
      end
   end

   task automatic send(input logic idx, input logic [15:0] d, output int waited);
      waited  = 0;
      arg_stb = 1'b1;
      arg_dat = {idx, d};
      forever begin
         @(negedge clk);
         if (arg_rdy) begin
            if (idx == 1'b0) q0.push_back(d);
            else             q1.push_back(d);
            @(posedge clk); #1;
            break;
         end
         @(posedge clk); #1;
         waited++;
         if (waited > 20) begin
            check("send_timeout", 64'(waited), 64'd0);
            break;
         end
      end
      arg_stb = 1'b0;
   endtask

   task automatic drain(input int ch);
      int t;
      t = 0;
      res_rdy[ch] = 1'b1;
      while (((ch == 0) ? q0.size() : q1.size()) != 0 || res_stb[ch]) begin
         @(posedge clk); #1;
         t++;
         if (t > 20) begin
            check("drain_timeout", 64'(t), 64'd0);
            break;
         end
      end
      res_rdy[ch] = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w;
      int p0;
      pops[0] = 0; pops[1] = 0;
      rst = 1'b1; arg_stb = 1'b0; arg_dat = '0; res_rdy = '0;
      a3_stb = 1'b0; a3_dat = '0; r3_rdy = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_res_stb", 64'(res_stb), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_res3_stb", 64'(r3_stb), 64'd0);
      check("rst_err3", 64'(err3), 64'd0);
      arg_dat = {1'b1, 16'h0000}; #1;
      check("rst_rdy_idx1", 64'(arg_rdy), 64'd1);
      arg_dat = {1'b0, 16'h0000}; #1;
      check("rst_rdy_idx0", 64'(arg_rdy), 64'd1);
      @(posedge clk); #1;

      // Single word to channel 1
      send(1'b1, 16'h00AB, w);
      check("single_wait", 64'(w), 64'd0);
      @(negedge clk);
      check("single_stb", 64'(res_stb), 64'h2);
      check("single_dat", 64'(res_dat[31:16]), 64'h00AB);
      @(posedge clk); #1 res_rdy[1] = 1'b1;
      @(posedge clk); #1 res_rdy[1] = 1'b0;
      @(negedge clk);
      check("single_popped", 64'(res_stb), 64'd0);
      check("single_pops", 64'(pops[1]), 64'd1);
      @(posedge clk); #1;

      // Backpressure: third word waits for a one-cycle pop pulse
      send(1'b0, 16'h0001, w);
      send(1'b0, 16'h0002, w);
      check("bp_second_wait", 64'(w), 64'd0);
      fork
         send(1'b0, 16'h0003, w);
         begin
            repeat (2) @(posedge clk);
            #1 res_rdy[0] = 1'b1;
            @(negedge clk);
            check("bp_no_rdy_path", 64'(arg_rdy), 64'd0);
            @(posedge clk);
            #1 res_rdy[0] = 1'b0;
         end
      join
      check("bp_third_wait", 64'(w), 64'd3);
      drain(0);
      check("bp_pops", 64'(pops[0]), 64'd3);

      // Channel isolation: channel 0 full and stalled, channel 1 flows
      send(1'b0, 16'h0010, w);
      send(1'b0, 16'h0011, w);
      check("iso_ch0_full", 64'(arg_rdy), 64'd0);
      res_rdy[1] = 1'b1;
      send(1'b1, 16'h0020, w);
      check("iso_wait_a", 64'(w), 64'd0);
      send(1'b1, 16'h0021, w);
      check("iso_wait_b", 64'(w), 64'd0);
      drain(1);
      check("iso_ch1_pops", 64'(pops[1]), 64'd3);
      check("iso_ch0_held", 64'(pops[0]), 64'd3);
      drain(0);
      check("iso_ch0_pops", 64'(pops[0]), 64'd5);

      // Simultaneous push/pop holding occupancy at one
      send(1'b0, 16'h0050, w);
      p0 = pops[0];
      res_rdy[0] = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         send(1'b0, 16'h0050 + i[15:0], w);
         check("pp_wait", 64'(w), 64'd0);
      end
      res_rdy[0] = 1'b0;
      check("pp_pops", 64'(pops[0] - p0), 64'd5);
      @(negedge clk);
      check("pp_stb", 64'(res_stb[0]), 64'd1);
      check("pp_head", 64'(res_dat[15:0]), 64'h0055);
      @(posedge clk); #1;
      drain(0);

      // Out-of-range index on the three-channel instance
      a3_stb = 1'b1;
      a3_dat = {2'd3, 16'h1234};
      @(negedge clk);
      check("oor_rdy", 64'(a3_rdy), 64'd1);
      @(posedge clk); #1 a3_stb = 1'b0;
      @(negedge clk);
      check("oor_stb", 64'(r3_stb), 64'd0);
      check("oor_err", 64'(err3), 64'd1);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("oor_err_sticky", 64'(err3), 64'd1);
      check("oor_stb_hold", 64'(r3_stb), 64'd0);
      a3_stb = 1'b1;
      a3_dat = {2'd2, 16'hBEEF};
      @(posedge clk); #1 a3_stb = 1'b0;
      @(negedge clk);
      check("ch2_stb", 64'(r3_stb), 64'h4);
      check("ch2_dat", 64'(r3_dat[47:32]), 64'hBEEF);
      check("no_err_pow2", 64'(err), 64'd0);

      // Reset mid-stream with a handshake in flight
      @(posedge clk); #1;
      send(1'b0, 16'h0060, w);
      send(1'b1, 16'h0061, w);
      check("mid_stb_before", 64'(res_stb), 64'h3);
      arg_stb = 1'b1;
      arg_dat = {1'b0, 16'h0062};
      rst = 1'b1;
      q0.delete();
      q1.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      arg_stb = 1'b0;
      @(negedge clk);
      check("mid_res_stb", 64'(res_stb), 64'd0);
      check("mid_err", 64'(err), 64'd0);
      check("mid_err3", 64'(err3), 64'd0);
      check("mid_res3_stb", 64'(r3_stb), 64'd0);
      check("mid_rdy", 64'(arg_rdy), 64'd1);
      @(negedge clk);
      check("mid_no_inflight", 64'(res_stb), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
